// File: rtl/load_store_unit.sv
// RV32I memory stage: word-aligns accesses to the address decoder, performs
// read-modify-write for sub-word stores and extends sub-word load results.
module load_store_unit #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] ea,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] addr,
  output logic        WE,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [2:0] LAST = 3'(RD_LATENCY);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Misaligned halfword/word, store with an unsigned size code, or reserved load code.
  function automatic logic illegal(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic bad_f3, bad_align;
    bad_f3    = st ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    bad_align = (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
    return bad_f3 || bad_align;
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    if (f3[1:0] == 2'b00)      m[{lane, 3'b000} +: 8]     = wd[7:0];
    else if (f3[1:0] == 2'b01) m[{lane[1], 4'b0000} +: 16] = wd[15:0];
    else                       m = wd;
    return m;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (req) begin
          store_d = is_store;
          f3_d    = funct3;
          lane_d  = ea[1:0];
          wdata_d = wdata;
          cnt_d   = 3'd0;
          if (illegal(is_store, funct3, ea[1:0])) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            err_d  = 1'b0;
            addr_d = {ea[31:2], 2'b00};
            if (is_store && funct3 == 3'b010) begin
              state_d     = WRITE;
              we_d        = 1'b1;
              mem_wdata_d = wdata;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        // The word is valid on the final READ edge; sub-word stores merge it here.
        if (cnt_q == LAST) begin
          if (store_q) begin
            state_d     = WRITE;
            we_d        = 1'b1;
            mem_wdata_d = merge(f3_q, lane_q, mem_rdata, wdata_q);
          end else begin
            state_d = DONE;
            rdata_d = extend(f3_q, lane_q, mem_rdata);
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      store_q     <= 1'b0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 32'd0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      mem_wdata_q <= 32'd0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign addr      = addr_q;
  assign WE        = we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == READ) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// word-array memory and an arithmetic reference model of each RV32I access.
module tb_load_store_unit;
  localparam int RDL = 1;

  logic        clk = 1'b0;
  logic        rst, req, is_store;
  logic [2:0]  funct3;
  logic [31:0] ea, wdata, mem_rdata;
  logic [31:0] addr, mem_wdata, rdata;
  logic        WE, busy, done, err;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        fill, bk_we;
  logic [11:0] bk_idx;
  logic [31:0] bk_data;
  logic [31:0] exp_addr, exp_rdata;

  load_store_unit #(.RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .ea(ea), .wdata(wdata), .mem_rdata(mem_rdata), .addr(addr), .WE(WE),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory behind the decoder: one-edge read latency, write on WE.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else if (bk_we) begin
      mem[bk_idx] <= bk_data;
    end else if (WE) begin
      mem[addr[13:2]] <= mem_wdata;
    end
    mem_rdata <= mem[addr[13:2]];
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned acc_size(logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit op_error(bit st, logic [2:0] f3, logic [31:0] a);
    int unsigned size = acc_size(f3);
    if (size == 0) return 1'b1;
    if (st && f3 > 3'd3) return 1'b1;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] load_value(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    int unsigned sh = 8 * (a % 4);
    logic [7:0]  b = 8'(w >> sh);
    logic [15:0] h = 16'(w >> sh);
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(logic [2:0] f3, logic [31:0] a,
                                              logic [31:0] old, logic [31:0] wd);
    int unsigned sh = 8 * (a % 4);
    logic [31:0] mask;
    case (acc_size(f3))
      1:       mask = 32'h0000_00FF << sh;
      2:       mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic backdoor(logic [31:0] byte_addr, logic [31:0] data);
    bk_we = 1'b1; bk_idx = byte_addr[13:2]; bk_data = data;
    ref_mem[byte_addr[13:2]] = data;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  // Issues one request (caller sits at a negedge) and follows it to done.
  task automatic do_op(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, string tag);
    bit e, seen_done;
    int lat, cyc, wes;
    logic [31:0] old_word, new_word;
    e        = op_error(st, f3, a);
    old_word = ref_mem[a[13:2]];
    new_word = st ? store_merge(f3, a, old_word, wd) : old_word;
    lat      = e ? 1 : (st && f3 == 3'd2) ? 2 : st ? RDL + 3 : RDL + 2;
    req = 1'b1; is_store = st; funct3 = f3; ea = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
    ea = $urandom; wdata = $urandom;
    cyc = 0; wes = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (WE) begin
        wes++;
        check({tag, ".we_addr"}, addr, {a[31:2], 2'b00});
        check({tag, ".we_data"}, mem_wdata, new_word);
      end
      if (done) seen_done = 1'b1;
      else      check({tag, ".busy"}, 32'(busy), 32'd1);
    end
    check({tag, ".done_seen"}, 32'(seen_done), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".we_count"}, 32'(wes), (st && !e) ? 32'd1 : 32'd0);
    check({tag, ".err"}, 32'(err), 32'(e));
    if (e)        exp_rdata = 32'd0;
    else if (!st) exp_rdata = load_value(f3, a, old_word);
    if (!e)       exp_addr  = {a[31:2], 2'b00};
    if (!e && st) ref_mem[a[13:2]] = new_word;
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".addr"}, addr, exp_addr);
  endtask

  initial begin
    logic [2:0] f3_tab [0:7];
    bit st, saw_we, saw_done;
    logic [2:0] f3;
    logic [31:0] a;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
    rst = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; ea = 32'd0; wdata = 32'd0;
    fill = 1'b1; bk_we = 1'b0; bk_idx = 12'd0; bk_data = 32'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    exp_addr = 32'd0; exp_rdata = 32'd0;

    @(posedge clk); @(posedge clk); #1;
    fill = 1'b0;
    @(negedge clk);
    check("rst.WE", 32'(WE), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.addr", addr, 32'd0);
    check("rst.rdata", rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b1, 3'd2, 32'h0000_0204, 32'hDEAD_BEEF, "sw");
    check("sw.mem", mem[12'h081], 32'hDEAD_BEEF);

    backdoor(32'h248, 32'h1280_7F00);
    do_op(1'b0, 3'd0, 32'h0000_024A, 32'h0, "lb");
    check("lb.value", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 3'd4, 32'h0000_024A, 32'h0, "lbu");
    check("lbu.value", rdata, 32'h0000_0080);

    backdoor(32'h248, 32'h1122_3344);
    do_op(1'b1, 3'd0, 32'h0000_0249, 32'h0000_00AB, "sb");
    check("sb.mem", mem[12'h092], 32'h1122_AB44);

    do_op(1'b0, 3'd2, 32'h0000_1EE2, 32'h0, "lw_mis");
    do_op(1'b1, 3'd1, 32'h0000_1249, 32'h1234_5678, "sh_mis");
    check("sh_mis.mem", mem[12'h492], ref_mem[12'h492]);

    @(negedge clk);
    check("idle.done", 32'(done), 32'd0);
    check("idle.busy", 32'(busy), 32'd0);

    // Random traffic, mixing back-to-back requests with idle gaps.
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom);
      f3 = f3_tab[$urandom_range(st ? 6 : 7, 0)];
      a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(16383, 0));
      if ($urandom_range(3, 0) != 0) a[1:0] = 2'($urandom_range(3, 0) == 0 ? 1 : 0) * a[1:0];
      do_op(st, f3, a, $urandom, "rand");
      if ($urandom_range(2, 0) == 0) begin
        @(negedge clk);
        check("rand.gap_done", 32'(done), 32'd0);
      end
    end
    for (int i = 0; i < 4096; i += 97) check("final.mem", mem[i], ref_mem[i]);

    // Reset while a byte store is reading: it must abort without writing.
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'd0; ea = 32'h0000_0301; wdata = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.WE", 32'(WE), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    rst = 1'b1;
    saw_we = 1'b0; saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (WE)   saw_we = 1'b1;
      if (done) saw_done = 1'b1;
    end
    check("abort.no_we", 32'(saw_we), 32'd0);
    check("abort.no_done", 32'(saw_done), 32'd0);
    check("abort.mem", mem[12'h0C0], ref_mem[12'h0C0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
